// File: rtl/sync_updown_counter_nbit.sv
// ============================================================================
// Module   : sync_updown_counter_nbit
// Summary  : Synchronous N-bit up/down counter with programmable terminal
//            value, parallel load, enable, one-shot mode and wrap pulse.
//            Optional Gray output enabled by macro SYNC_COUNTER_GRAY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_updown_counter_nbit #(
    parameter int              N         = 7,
    parameter int              ONE_SHOT  = 0,
    parameter logic [N-1:0]    RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          up_dn,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    input  logic [N-1:0]  mod_max,
    output logic [N-1:0]  Q,
    output logic          wrap,
    output logic          done,
    output logic [N-1:0]  q_gray
);

    localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_q;
    logic         r_wrap;
    logic [N-1:0] w_q_next;
    logic         w_at_top;
    logic         w_at_bot;
    logic         w_count;
    logic         w_wrap_evt;
    logic         w_done;

    // Out-of-range counts (above mod_max) are treated as terminal in both
    // directions so a bad load always re-enters the legal range in one step.
    always_comb begin
        w_at_top   = (r_q >= mod_max);
        w_at_bot   = (r_q == '0) || (r_q > mod_max);
        w_count    = en && !load && !w_done;
        w_wrap_evt = w_count && (up_dn ? w_at_top : w_at_bot);
        w_q_next   = r_q;
        if (load) begin
            w_q_next = load_val;
        end else if (w_count) begin
            if (w_wrap_evt) begin
                if (ONE_SHOT == 0) begin
                    w_q_next = up_dn ? '0 : mod_max;
                end
            end else begin
                w_q_next = up_dn ? (r_q + c_ONE) : (r_q - c_ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_evt;
        end
    end

    generate
        if (ONE_SHOT != 0) begin : g_one_shot
            logic r_done;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_done <= 1'b0;
                end else if (load) begin
                    r_done <= 1'b0;
                end else if (w_wrap_evt) begin
                    r_done <= 1'b1;
                end
            end
            assign w_done = r_done;
        end else begin : g_free_run
            assign w_done = 1'b0;
        end
    endgenerate

`ifdef SYNC_COUNTER_GRAY_OUT_EN
    localparam logic [N-1:0] c_GRAY_RST = RESET_VAL ^ (RESET_VAL >> 1);

    // Encoded from the next state so the Gray value lines up with Q.
    logic [N-1:0] r_q_gray;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q_gray <= c_GRAY_RST;
        end else begin
            r_q_gray <= w_q_next ^ (w_q_next >> 1);
        end
    end
    assign q_gray = r_q_gray;
`else
    assign q_gray = '0;
`endif

    assign Q    = r_q;
    assign wrap = r_wrap;
    assign done = w_done;

endmodule

`default_nettype wire
